// File: rtl/issue_scoreboard_ctrl_if.sv
// Decode/issue/writeback bundle between decode, the issue controller and the EXU.
interface issue_scoreboard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             dec_vld;
  logic             dec_rdy;
  logic [4:0]       dec_rd;
  logic [4:0]       dec_rs1;
  logic [4:0]       dec_rs2;
  logic             dec_use_rs1;
  logic             dec_use_rs2;
  logic             dec_wen;
  logic             dec_div;
  logic             dec_serial;
  logic             dec_halt;
  logic             iss_vld;
  logic             iss_rdy;
  logic             wb_vld;
  logic [4:0]       wb_rd;
  logic             div_done;
  logic             flush;
  logic             halted;
  logic [CNT_W-1:0] perf_stall_cnt;

  modport master (
    output dec_vld, dec_rd, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
           dec_wen, dec_div, dec_serial, dec_halt, iss_rdy, wb_vld, wb_rd,
           div_done, flush,
    input  dec_rdy, iss_vld, halted, perf_stall_cnt
  );

  modport slave (
    input  dec_vld, dec_rd, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
           dec_wen, dec_div, dec_serial, dec_halt, iss_rdy, wb_vld, wb_rd,
           div_done, flush,
    output dec_rdy, iss_vld, halted, perf_stall_cnt
  );
endinterface

// File: rtl/issue_scoreboard_ctrl.sv
// Issue controller: register scoreboard, divider arbitration, serialising drain,
// ebreak halt and a saturating stall-cycle counter.
module issue_scoreboard_ctrl #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  issue_scoreboard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_e;

  state_e           state_q, state_d;
  logic [NREG-1:0]  pending_q, pending_d;
  logic [NREG-1:0]  wb_vec, set_vec, rdy_vec, pend_after_wb;
  logic             div_busy_q, div_busy_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             raw, waw, divh, serh, stall, dec_rdy_c, fire;

  // Hazard check, handshake and next-state computation
  always_comb begin
    wb_vec = '0;
    if (bus.wb_vld) wb_vec[bus.wb_rd] = 1'b1;
    pend_after_wb = pending_q & ~wb_vec;

    // Write-through regfile: a same-cycle writeback makes the register ready
    rdy_vec    = ~pending_q | wb_vec;
    rdy_vec[0] = 1'b1;

    raw   = (bus.dec_use_rs1 & ~rdy_vec[bus.dec_rs1]) |
            (bus.dec_use_rs2 & ~rdy_vec[bus.dec_rs2]);
    waw   = bus.dec_wen & ~rdy_vec[bus.dec_rd];
    divh  = bus.dec_div & div_busy_q & ~bus.div_done;
    serh  = bus.dec_serial & ((|pend_after_wb) | div_busy_q);
    stall = raw | waw | divh | serh | (state_q != RUN) | bus.flush;

    dec_rdy_c = bus.iss_rdy & ~stall;
    fire      = bus.dec_vld & dec_rdy_c;

    // Set after clear so a same-register issue wins over its writeback
    set_vec = '0;
    if (fire & bus.dec_wen & (bus.dec_rd != 5'd0)) set_vec[bus.dec_rd] = 1'b1;
    pending_d  = pend_after_wb | set_vec;
    div_busy_d = (fire & bus.dec_div) | (div_busy_q & ~bus.div_done);

    state_d = state_q;
    case (state_q)
      RUN: begin
        if (fire & bus.dec_serial)    state_d = DRAIN;
        else if (fire & bus.dec_halt) state_d = HALT;
      end
      DRAIN: begin
        if ((pending_d == '0) & ~div_busy_d) state_d = RUN;
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
    halted_d = (state_d == HALT);

    cnt_d = cnt_q;
    if (bus.dec_vld & ~dec_rdy_c & (state_q != HALT) & (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pending_q  <= '0;
      div_busy_q <= 1'b0;
      halted_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      div_busy_q <= div_busy_d;
      halted_q   <= halted_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.dec_rdy        = dec_rdy_c;
  assign bus.iss_vld        = fire;
  assign bus.halted         = halted_q;
  assign bus.perf_stall_cnt = cnt_q;

endmodule

// File: tb/tb_issue_scoreboard_ctrl.sv
// Randomized + directed bench for issue_scoreboard_ctrl with a queue-based scoreboard
// fed by a register-set reference model.
module tb_issue_scoreboard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic rst4_n;
  always #5 clk = ~clk;

  issue_scoreboard_ctrl_if #(.CNT_W(32)) bif ();
  issue_scoreboard_ctrl_if #(.CNT_W(4))  bif4 ();

  issue_scoreboard_ctrl #(.NREG(32), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bif)
  );
  issue_scoreboard_ctrl #(.NREG(32), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .bus(bif4)
  );

  typedef struct {
    logic        rdy;
    logic        vld;
    logic        halted;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model: set of in-flight destinations plus a few flags
  bit     m_pend[32];
  bit     m_busy, m_drain, m_halt;
  longint m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: compare DUT outputs against the oldest expected entry
  always @(negedge clk) begin : mon
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("dec_rdy", 32'(bif.dec_rdy), 32'(e.rdy));
      chk("iss_vld", 32'(bif.iss_vld), 32'(e.vld));
      chk("halted", 32'(bif.halted), 32'(e.halted));
      chk("perf_stall_cnt", bif.perf_stall_cnt, e.cnt);
    end
  end

  function automatic bit reg_ready(input logic [4:0] r);
    return (r == 5'd0) || !m_pend[r] || (bif.wb_vld && bif.wb_rd == r);
  endfunction

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_busy = 0; m_drain = 0; m_halt = 0; m_cnt = 0;
  endtask

  task automatic idle();
    bif.dec_vld = 0; bif.dec_rd = '0; bif.dec_rs1 = '0; bif.dec_rs2 = '0;
    bif.dec_use_rs1 = 0; bif.dec_use_rs2 = 0; bif.dec_wen = 0; bif.dec_div = 0;
    bif.dec_serial = 0; bif.dec_halt = 0; bif.iss_rdy = 1; bif.wb_vld = 0;
    bif.wb_rd = '0; bif.div_done = 0; bif.flush = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
  endtask

  // one cycle: predict, queue the expectation, advance the model
  task automatic step();
    bit rdy, fire, anyp;
    rdy = bif.iss_rdy;
    if (m_drain || m_halt || bif.flush) rdy = 0;
    if (bif.dec_use_rs1 && !reg_ready(bif.dec_rs1)) rdy = 0;
    if (bif.dec_use_rs2 && !reg_ready(bif.dec_rs2)) rdy = 0;
    if (bif.dec_wen && !reg_ready(bif.dec_rd)) rdy = 0;
    if (bif.dec_div && m_busy && !bif.div_done) rdy = 0;
    if (bif.dec_serial) begin
      anyp = m_busy;
      for (int r = 1; r < 32; r++)
        if (m_pend[r] && !(bif.wb_vld && bif.wb_rd == 5'(r))) anyp = 1;
      if (anyp) rdy = 0;
    end
    fire = bif.dec_vld && rdy;
    q.push_back('{rdy: rdy, vld: fire, halted: m_halt, cnt: m_cnt[31:0]});

    if (bif.dec_vld && !rdy && !m_halt && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    if (bif.wb_vld) m_pend[bif.wb_rd] = 0;
    if (fire && bif.dec_wen && bif.dec_rd != 5'd0) m_pend[bif.dec_rd] = 1;
    if (bif.div_done) m_busy = 0;
    if (fire && bif.dec_div) m_busy = 1;
    if (m_drain) begin
      anyp = m_busy;
      foreach (m_pend[i]) if (m_pend[i]) anyp = 1;
      if (!anyp) m_drain = 0;
    end else if (!m_halt) begin
      if (fire && bif.dec_serial) m_drain = 1;
      else if (fire && bif.dec_halt) m_halt = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic op(input bit wen, input logic [4:0] rd, input bit u1, input logic [4:0] rs1);
    idle();
    bif.dec_vld = 1; bif.dec_wen = wen; bif.dec_rd = rd;
    bif.dec_use_rs1 = u1; bif.dec_rs1 = rs1;
  endtask

  function automatic logic [4:0] rnd_reg();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic rand_cycle(input int halt_per_mille);
    int pl[$];
    int k;
    idle();
    bif.dec_vld = ($urandom_range(0, 99) < 70);
    bif.dec_rd = rnd_reg(); bif.dec_rs1 = rnd_reg(); bif.dec_rs2 = rnd_reg();
    bif.dec_use_rs1 = $urandom_range(0, 1) == 1;
    bif.dec_use_rs2 = $urandom_range(0, 1) == 1;
    bif.dec_wen = ($urandom_range(0, 99) < 75);
    bif.dec_div = ($urandom_range(0, 99) < 15);
    k = $urandom_range(0, 999);
    if (k < 40) bif.dec_serial = 1;
    else if (k < 40 + halt_per_mille) bif.dec_halt = 1;
    bif.iss_rdy = ($urandom_range(0, 99) < 85);
    bif.flush = ($urandom_range(0, 99) < 8);
    bif.div_done = m_busy ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 3);
    if ($urandom_range(0, 99) < 45) begin
      bif.wb_vld = 1;
      foreach (m_pend[i]) if (m_pend[i]) pl.push_back(i);
      if (pl.size() > 0 && $urandom_range(0, 3) != 0)
        bif.wb_rd = 5'(pl[$urandom_range(0, pl.size() - 1)]);
      else
        bif.wb_rd = rnd_reg();
    end
    step();
  endtask

  initial begin
    rst_n = 0;
    rst4_n = 0;
    bif4.dec_vld = 1; bif4.dec_rd = '0; bif4.dec_rs1 = '0; bif4.dec_rs2 = '0;
    bif4.dec_use_rs1 = 0; bif4.dec_use_rs2 = 0; bif4.dec_wen = 0; bif4.dec_div = 0;
    bif4.dec_serial = 0; bif4.dec_halt = 0; bif4.iss_rdy = 0; bif4.wb_vld = 0;
    bif4.wb_rd = '0; bif4.div_done = 0; bif4.flush = 0;
    do_reset();

    // RAW on x5, resolved by same-cycle writeback
    op(1, 5'd5, 0, 5'd0); step();
    op(1, 5'd6, 1, 5'd5); bif.dec_use_rs2 = 1; bif.dec_rs2 = 5'd1;
    repeat (3) step();
    bif.wb_vld = 1; bif.wb_rd = 5'd5; step();

    // x0 never pending; WAW on x7
    do_reset();
    op(1, 5'd0, 0, 5'd0); step();
    op(1, 5'd1, 1, 5'd0); step();
    op(1, 5'd7, 0, 5'd0); step();
    op(1, 5'd7, 0, 5'd0); step(); step();
    bif.wb_vld = 1; bif.wb_rd = 5'd7; step();

    // divider: second div waits, issues in the done cycle, busy stays set
    do_reset();
    op(1, 5'd2, 0, 5'd0); bif.dec_div = 1; step();
    op(1, 5'd3, 0, 5'd0); bif.dec_div = 1; step(); step();
    bif.div_done = 1; step();
    op(1, 5'd4, 0, 5'd0); bif.dec_div = 1; step();
    idle(); bif.div_done = 1; step();

    // serial: waits for x3, drains until its own writeback
    do_reset();
    op(1, 5'd3, 0, 5'd0); step();
    op(1, 5'd10, 0, 5'd0); bif.dec_serial = 1; step(); step();
    bif.wb_vld = 1; bif.wb_rd = 5'd3; step();
    op(1, 5'd11, 1, 5'd1); step(); step();
    bif.wb_vld = 1; bif.wb_rd = 5'd10; step();
    op(1, 5'd11, 1, 5'd1); step(); step();

    // ebreak halts permanently
    do_reset();
    op(0, 5'd0, 0, 5'd0); bif.dec_halt = 1; step();
    op(1, 5'd1, 0, 5'd0); repeat (4) step();

    // reset mid-drain with a pending register
    do_reset();
    op(1, 5'd4, 0, 5'd0); bif.dec_serial = 1; step();
    op(1, 5'd5, 1, 5'd4); step();
    do_reset();
    op(1, 5'd5, 1, 5'd4); step();

    // flush drops the instruction without touching the scoreboard
    do_reset();
    op(1, 5'd9, 0, 5'd0); bif.flush = 1; step();
    op(1, 5'd8, 1, 5'd9); step();

    // random traffic, first without halts then with occasional ebreak
    do_reset();
    repeat (1500) rand_cycle(0);
    do_reset();
    repeat (1500) rand_cycle(3);
    do_reset();

    // narrow counter saturates
    idle();
    @(posedge clk); #1;
    rst4_n = 1;
    repeat (10) @(posedge clk);
    #1;
    chk("cnt4_after_10", 32'(bif4.perf_stall_cnt), 32'd10);
    chk("cnt4_dec_rdy", 32'(bif4.dec_rdy), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("cnt4_saturated", 32'(bif4.perf_stall_cnt), 32'd15);

    chk("scoreboard_queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
